// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl: multi-cycle RV64 control FSM with memory timeout/fault    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int CNT_BITS = 64,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                pc_load,
  output logic                pc_src,
  output logic                ir_load,
  output logic                ab_load,
  output logic                aluout_load,
  output logic                mdr_load,
  output logic                rf_write,
  output logic                wb_src,
  output logic [2:0]          state,
  output logic [CNT_BITS-1:0] instret,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_decode = 3'd2;
  localparam logic [2:0] c_st_exec   = 3'd3;
  localparam logic [2:0] c_st_mem    = 3'd4;
  localparam logic [2:0] c_st_wb     = 3'd5;
  localparam logic [2:0] c_st_halt   = 3'd7;

  localparam logic [2:0] c_cls_r      = 3'd0;
  localparam logic [2:0] c_cls_i      = 3'd1;
  localparam logic [2:0] c_cls_load   = 3'd2;
  localparam logic [2:0] c_cls_store  = 3'd3;
  localparam logic [2:0] c_cls_branch = 3'd4;
  localparam logic [2:0] c_cls_lui    = 3'd5;

  // Counter only needs to reach TIMEOUT-1; the compare is done one bit wider.
  localparam int         TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW:0] c_tmo = (TW + 1)'(TIMEOUT);

  logic [2:0]          state_q, state_d;
  logic [2:0]          cls_q, cls_d;
  logic [CNT_BITS-1:0] instret_q, instret_d;
  logic [1:0]          fcode_q, fcode_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;

  logic [2:0] w_dec_cls;
  logic       w_dec_ok;
  logic       w_wait;
  logic       w_tmo;
  logic       w_retire;

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_cls = c_cls_r;
    case (opcode)
      7'b0110011: w_dec_cls = c_cls_r;
      7'b0010011: w_dec_cls = c_cls_i;
      7'b0000011: w_dec_cls = c_cls_load;
      7'b0100011: w_dec_cls = c_cls_store;
      7'b1100011: w_dec_cls = c_cls_branch;
      7'b0110111: w_dec_cls = c_cls_lui;
      default:    w_dec_ok  = 1'b0;
    endcase
  end

  assign w_wait = ((state_q == c_st_fetch) || (state_q == c_st_mem)) && !mem_ready;
  assign w_tmo  = w_wait && (c_tmo != '0) &&
                  (({1'b0, tmo_cnt_q} + {{TW{1'b0}}, 1'b1}) == c_tmo);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    instret_d   = instret_q;
    fcode_d     = fcode_q;
    w_retire    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 1'b0;
    ir_load     = 1'b0;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    mdr_load    = 1'b0;
    rf_write    = 1'b0;
    wb_src      = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (run) state_d = c_st_fetch;
      end
      c_st_fetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          state_d = c_st_decode;
        end else if (w_tmo) begin
          state_d = c_st_halt;
          fcode_d = 2'b10;
        end
      end
      c_st_decode: begin
        ab_load = 1'b1;
        if (w_dec_ok) begin
          cls_d   = w_dec_cls;
          state_d = c_st_exec;
        end else begin
          state_d = c_st_halt;
          fcode_d = 2'b01;
        end
      end
      c_st_exec: begin
        aluout_load = 1'b1;
        case (cls_q)
          c_cls_branch: begin
            pc_load  = branch_taken;
            pc_src   = 1'b1;
            w_retire = 1'b1;
          end
          c_cls_load, c_cls_store: state_d = c_st_mem;
          default:                 state_d = c_st_wb;
        endcase
      end
      c_st_mem: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == c_cls_store);
        if (mem_ready) begin
          if (cls_q == c_cls_store) begin
            w_retire = 1'b1;
          end else begin
            mdr_load = 1'b1;
            state_d  = c_st_wb;
          end
        end else if (w_tmo) begin
          state_d = c_st_halt;
          fcode_d = 2'b10;
        end
      end
      c_st_wb: begin
        rf_write = 1'b1;
        wb_src   = (cls_q == c_cls_load);
        w_retire = 1'b1;
      end
      c_st_halt: ;
      default: state_d = c_st_idle;
    endcase

    if (w_retire) begin
      instret_d = instret_q + CNT_BITS'(1);
      state_d   = run ? c_st_fetch : c_st_idle;
    end
  end

  // Any state change (including retire back into FETCH) restarts the wait count.
  always_comb begin
    if (state_d != state_q) tmo_cnt_d = '0;
    else if (w_wait)        tmo_cnt_d = tmo_cnt_q + TW'(1);
    else                    tmo_cnt_d = tmo_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_st_idle;
      cls_q     <= c_cls_r;
      instret_q <= '0;
      fcode_q   <= 2'b00;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
      fcode_q   <= fcode_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign state      = state_q;
  assign instret    = instret_q;
  assign fault      = (state_q == c_st_halt);
  assign fault_code = fcode_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl: randomized instruction-level check of multicycle_ctrl  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam int CNT = 4;
  localparam int TMO = 4;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd7;

  // Flag order: mem_req mem_we pc_load pc_src ir_load ab_load aluout_load mdr_load rf_write wb_src
  localparam logic [9:0] F_REQ = 10'h200, F_WE  = 10'h100, F_PC  = 10'h080, F_PCSRC = 10'h040,
                         F_IR  = 10'h020, F_AB  = 10'h010, F_ALU = 10'h008, F_MDR   = 10'h004,
                         F_RF  = 10'h002, F_WBS = 10'h001;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_LUI = 5;

  typedef struct {
    logic [2:0] st;
    int         rdy;     // 0/1 forced, 2 = random (don't care)
    logic [9:0] fl;
    bit         retire;
  } step_t;

  logic           clk = 1'b0;
  logic           rst_n, run, branch_taken, mem_ready;
  logic [6:0]     opcode;
  logic           mem_req, mem_we, pc_load, pc_src, ir_load, ab_load;
  logic           aluout_load, mdr_load, rf_write, wb_src, fault;
  logic [2:0]     state;
  logic [CNT-1:0] instret;
  logic [1:0]     fault_code;
  logic [31:0]    dut_vec;

  int n_total = 0;
  int n_bad   = 0;
  int m_instret = 0;
  bit m_idle = 1'b1;

  logic [6:0] legal_ops [6];

  multicycle_ctrl #(.CNT_BITS(CNT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .pc_load(pc_load), .pc_src(pc_src),
    .ir_load(ir_load), .ab_load(ab_load), .aluout_load(aluout_load),
    .mdr_load(mdr_load), .rf_write(rf_write), .wb_src(wb_src),
    .state(state), .instret(instret), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  assign dut_vec = {12'b0, state, mem_req, mem_we, pc_load, pc_src, ir_load, ab_load,
                    aluout_load, mdr_load, rf_write, wb_src, fault, fault_code, instret};

  function automatic logic [31:0] mk(logic [2:0] st, logic [9:0] fl, logic f,
                                     logic [1:0] c, int ins);
    logic [CNT-1:0] ins_w;
    ins_w = CNT'(ins);
    return {12'b0, st, fl, f, c, ins_w};
  endfunction

  function automatic int cls_of(logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b0110111: return K_LUI;
      default:    return -1;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%05h expected=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic rdy, input logic [6:0] op, input logic bt, input logic rn);
    @(negedge clk);
    mem_ready = rdy; opcode = op; branch_taken = bt; run = rn;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset", dut_vec, mk(ST_IDLE, 10'b0, 1'b0, 2'b00, 0));
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    m_instret = 0;
    m_idle = 1'b1;
  endtask

  // One instruction from the spec's view: waits, class-dependent phases, retire or halt.
  task automatic do_instr(input logic [6:0] op, input logic bt, input int fw, input int mw,
                          input logic run_end);
    step_t      q[$];
    int         cls;
    logic [1:0] hcode;
    logic [9:0] mf;
    hcode = 2'b00;
    cls   = cls_of(op);
    if (m_idle) q.push_back('{ST_IDLE, 2, 10'b0, 1'b0});
    m_idle = 1'b0;
    for (int i = 0; i < fw && i < TMO; i++) q.push_back('{ST_FETCH, 0, F_REQ, 1'b0});
    if (fw >= TMO) hcode = 2'b10;
    else begin
      q.push_back('{ST_FETCH, 1, F_REQ | F_IR | F_PC, 1'b0});
      q.push_back('{ST_DECODE, 2, F_AB, 1'b0});
      if (cls < 0) hcode = 2'b01;
      else if (cls == K_BR)
        q.push_back('{ST_EXEC, 2, F_ALU | F_PCSRC | (bt ? F_PC : 10'b0), 1'b1});
      else begin
        q.push_back('{ST_EXEC, 2, F_ALU, 1'b0});
        if (cls == K_LD || cls == K_ST) begin
          mf = F_REQ | ((cls == K_ST) ? F_WE : 10'b0);
          for (int i = 0; i < mw && i < TMO; i++) q.push_back('{ST_MEM, 0, mf, 1'b0});
          if (mw >= TMO) hcode = 2'b10;
          else q.push_back('{ST_MEM, 1, mf | ((cls == K_LD) ? F_MDR : 10'b0), cls == K_ST});
        end
        if (hcode == 2'b00 && cls != K_ST)
          q.push_back('{ST_WB, 2, F_RF | ((cls == K_LD) ? F_WBS : 10'b0), 1'b1});
      end
    end

    foreach (q[k]) begin
      @(negedge clk);
      mem_ready    = (q[k].rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(q[k].rdy);
      opcode       = (q[k].st == ST_DECODE) ? op : 7'($urandom);
      branch_taken = (q[k].st == ST_EXEC) ? bt : 1'($urandom_range(0, 1));
      run          = q[k].retire ? run_end
                   : ((q[k].st == ST_IDLE) ? 1'b1 : 1'($urandom_range(0, 1)));
      #1 check_val($sformatf("phase_st%0d_op%07b", q[k].st, op), dut_vec,
                   mk(q[k].st, q[k].fl, 1'b0, 2'b00, m_instret));
      if (q[k].retire) begin
        m_instret = (m_instret + 1) % (2 ** CNT);
        m_idle    = !run_end;
      end
    end

    if (hcode != 2'b00) begin
      for (int i = 0; i < 20; i++) begin
        cyc(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
        check_val("halt", dut_vec, mk(ST_HALT, 10'b0, 1'b1, hcode, m_instret));
      end
      do_reset();
    end else if (!run_end) begin
      cyc(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      check_val("idle_park", dut_vec, mk(ST_IDLE, 10'b0, 1'b0, 2'b00, m_instret));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [6:0] op;
    int fw, mw;
    legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
    legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b0110111;

    rst_n = 1'b0; run = 1'b0; opcode = 7'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    #3 check_val("reset_state", dut_vec, mk(ST_IDLE, 10'b0, 1'b0, 2'b00, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: ADD, LOAD with 3 waits, taken/not-taken branches, STORE, park in IDLE.
    do_instr(7'b0110011, 1'b0, 0, 0, 1'b1);
    do_instr(7'b0000011, 1'b0, 0, 3, 1'b1);
    do_instr(7'b1100011, 1'b1, 0, 0, 1'b1);
    do_instr(7'b1100011, 1'b0, 0, 0, 1'b1);
    do_instr(7'b0100011, 1'b0, 2, 1, 1'b0);
    do_instr(7'b0110111, 1'b0, 3, 0, 1'b1);
    do_instr(7'b1111111, 1'b0, 0, 0, 1'b1);
    do_instr(7'b0110011, 1'b0, 4, 0, 1'b1);
    do_instr(7'b0000011, 1'b0, 0, 4, 1'b1);
    do_instr(7'b0100011, 1'b0, 0, 3, 1'b1);

    // Async reset between edges while a load waits in MEM.
    cyc(1'b1, 7'b0, 1'b0, 1'b1);
    cyc(1'b1, 7'b0000011, 1'b0, 1'b1);
    cyc(1'b0, 7'b0, 1'b0, 1'b1);
    cyc(1'b0, 7'b0, 1'b0, 1'b1);
    check_val("mem_wait", dut_vec, mk(ST_MEM, F_REQ, 1'b0, 2'b00, m_instret));
    #2 rst_n = 1'b0;
    #1 check_val("reset_mid_mem", dut_vec, mk(ST_IDLE, 10'b0, 1'b0, 2'b00, 0));
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    m_instret = 0;
    m_idle = 1'b1;

    // Random instruction stream; 4-bit counter wraps several times.
    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 19);
      op = (r == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 5)];
      r  = $urandom_range(0, 15);
      fw = (r == 0) ? TMO : ((r < 9) ? 0 : $urandom_range(1, TMO - 1));
      r  = $urandom_range(0, 15);
      mw = (r == 0) ? TMO : ((r < 9) ? 0 : $urandom_range(1, TMO - 1));
      do_instr(op, 1'($urandom_range(0, 1)), fw, mw, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
